robo_coletor_param: RTL and testbench

- Parametrised next-generation collector-robot controller for the grid-map robot bench.
- Samples head/left/under/barrier once per clock and issues exactly one registered action per cycle: advance, turn (90° left), collect or remove.
- Adds the following on top of the basic wall follower:
  - multi-cycle barrier removal;
  - composite right turn;
  - once-per-cell collection with a capacity limit;
  - move/item counters;
  - a stuck watchdog.

---
 rtl/robo_coletor_param.sv | 166 ++++++++++++++++
 tb/tb_robo_coletor_param.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/robo_coletor_param.sv
// Collector-robot wall follower: one registered action per cycle, multi-cycle barrier removal.
// Define ROBO_WATCHDOG_EN to enable the turn-run watchdog (HALT state, stuck output).
module robo_coletor_param #(
    parameter int CAPACITY      = 8,
    parameter int REMOVE_CYCLES = 3,
    parameter int MAX_TURNS     = 8,
    parameter int CNT_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             head,
    input  logic             left,
    input  logic             under,
    input  logic             barrier,
    output logic             advance,
    output logic             turn,
    output logic             collect,
    output logic             remove,
    output logic             full,
    output logic             stuck,
    output logic [CNT_W-1:0] moves,
    output logic [CNT_W-1:0] items
);

    localparam int REM_W = (REMOVE_CYCLES > 1) ? $clog2(REMOVE_CYCLES) : 1;
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(REMOVE_CYCLES - 1);
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);

    typedef enum logic [2:0] {
        SEEK,
        FOLLOW,
        ENTER,
        ROT_R,
        REMOVE,
        HALT
    } state_t;

    state_t           state;
    state_t           saved;
    logic [1:0]       rot_cnt;
    logic [REM_W-1:0] rem_cnt;
    logic             cell_done;
    logic             can_collect;
    logic             wd_trip;

    assign full        = (items == CAP);
    assign can_collect = under && !cell_done && !full;

`ifdef ROBO_WATCHDOG_EN
    localparam int TR_W = $clog2(MAX_TURNS + 1);
    localparam logic [TR_W-1:0] TR_LAST = TR_W'(MAX_TURNS - 1);
    localparam logic [TR_W-1:0] TR_ONE  = TR_W'(1);

    logic [TR_W-1:0] turn_run;

    // Counts the registered turn pulses; the trip fires while the MAX_TURNS-th turn is visible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            turn_run <= '0;
        end else if (advance) begin
            turn_run <= '0;
        end else if (turn && turn_run != TR_W'(MAX_TURNS)) begin
            turn_run <= turn_run + TR_ONE;
        end
    end

    assign wd_trip = turn && (turn_run == TR_LAST);
    assign stuck   = (state == HALT);
`else
    assign wd_trip = 1'b0;
    assign stuck   = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= SEEK;
            saved     <= SEEK;
            rot_cnt   <= '0;
            rem_cnt   <= '0;
            cell_done <= 1'b0;
            advance   <= 1'b0;
            turn      <= 1'b0;
            collect   <= 1'b0;
            remove    <= 1'b0;
            moves     <= '0;
            items     <= '0;
        end else begin
            advance <= 1'b0;
            turn    <= 1'b0;
            collect <= 1'b0;
            remove  <= 1'b0;
            if (state == HALT) begin
                state <= HALT;
            end else if (wd_trip) begin
                state <= HALT;
            end else begin
                case (state)
                    SEEK, FOLLOW, ENTER: begin
                        if (can_collect) begin
                            collect   <= 1'b1;
                            items     <= items + CNT_ONE;
                            cell_done <= 1'b1;
                        end else if (barrier) begin
                            remove  <= 1'b1;
                            saved   <= state;
                            rem_cnt <= REM_INIT;
                            if (REMOVE_CYCLES > 1) begin
                                state <= REMOVE;
                            end
                        end else begin
                            // Wall-follow rule; a right turn is three left turns.
                            unique case (1'b1)
                                (state == SEEK && !head),
                                (state == FOLLOW && left && !head),
                                (state == ENTER && !head): begin
                                    advance   <= 1'b1;
                                    cell_done <= 1'b0;
                                    if (moves != '1) begin
                                        moves <= moves + CNT_ONE;
                                    end
                                    if (state == ENTER) begin
                                        state <= FOLLOW;
                                    end
                                end
                                (state == SEEK && head),
                                (state == FOLLOW && left && head): begin
                                    turn    <= 1'b1;
                                    rot_cnt <= 2'd2;
                                    state   <= ROT_R;
                                end
                                (state == FOLLOW && !left),
                                (state == ENTER && head): begin
                                    turn  <= 1'b1;
                                    state <= ENTER;
                                end
                                default: begin
                                    state <= SEEK;
                                end
                            endcase
                        end
                    end
                    ROT_R: begin
                        turn    <= 1'b1;
                        rot_cnt <= rot_cnt - 2'd1;
                        if (rot_cnt <= 2'd1) begin
                            state <= FOLLOW;
                        end
                    end
                    REMOVE: begin
                        remove  <= 1'b1;
                        rem_cnt <= rem_cnt - REM_ONE;
                        if (rem_cnt <= REM_ONE) begin
                            state <= saved;
                        end
                    end
                    default: begin
                        state <= SEEK;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_robo_coletor_param.sv
// Directed bench for robo_coletor_param (CAPACITY=2, REMOVE_CYCLES=3, MAX_TURNS=8).
module tb_robo_coletor_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       head, left, under, barrier;
    logic       advance, turn, collect, remove, full, stuck;
    logic [7:0] moves, items;
    logic [3:0] act;

    int n_checks = 0;
    int n_pass   = 0;

    robo_coletor_param #(
        .CAPACITY(2),
        .REMOVE_CYCLES(3),
        .MAX_TURNS(8),
        .CNT_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .head(head),
        .left(left),
        .under(under),
        .barrier(barrier),
        .advance(advance),
        .turn(turn),
        .collect(collect),
        .remove(remove),
        .full(full),
        .stuck(stuck),
        .moves(moves),
        .items(items)
    );

    always #5 clock = ~clock;

    assign act = {advance, turn, collect, remove};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_act(input string tag, input logic [3:0] exp);
        check(tag, 32'(act), 32'(exp));
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic h, input logic l, input logic u, input logic b);
        head    = h;
        left    = l;
        under   = u;
        barrier = b;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        tick();
        check_act("rst_act", 4'b0000);
        check("rst_moves", 32'(moves), 0);
        check("rst_items", 32'(items), 0);
        check("rst_full", 32'(full), 0);
        check("rst_stuck", 32'(stuck), 0);
        reset = 1'b0;

        // open field: SEEK advances every cycle
        for (int i = 0; i < 5; i++) begin
            tick();
            check_act("seek_adv", 4'b1000);
        end
        check("moves5", 32'(moves), 5);

        // wall ahead in SEEK: three turns then FOLLOW
        drive(1, 0, 0, 0);
        tick();
        check_act("rot1", 4'b0100);
        drive(0, 1, 0, 0);
        tick();
        check_act("rot2", 4'b0100);
        tick();
        check_act("rot3", 4'b0100);
        tick();
        check_act("follow_adv", 4'b1000);
        check("moves6", 32'(moves), 6);

        // once-per-cell collection
        drive(1, 1, 1, 0);
        tick();
        check_act("col1", 4'b0010);
        check("items1", 32'(items), 1);
        tick();
        check_act("col_once_a", 4'b0100);
        tick();
        check_act("col_once_b", 4'b0100);
        check("items1_hold", 32'(items), 1);
        tick();
        check_act("rot_back", 4'b0100);
        drive(0, 1, 1, 0);
        tick();
        check_act("cell_adv", 4'b1000);
        tick();
        check_act("col2", 4'b0010);
        check("items2", 32'(items), 2);
        check("full", 32'(full), 1);

        // full: under ignored, movement continues
        tick();
        check_act("full_adv", 4'b1000);
        tick();
        check_act("full_adv2", 4'b1000);
        check("items_cap", 32'(items), 2);

        // barrier removal, three cycles then FOLLOW rule resumes
        drive(0, 1, 0, 1);
        tick();
        check_act("rem1", 4'b0001);
        drive(0, 1, 0, 0);
        tick();
        check_act("rem2", 4'b0001);
        tick();
        check_act("rem3", 4'b0001);
        tick();
        check_act("rem_resume", 4'b1000);

        // reset during the second removal cycle
        drive(0, 0, 0, 1);
        tick();
        check_act("rem1b", 4'b0001);
        drive(0, 0, 0, 0);
        tick();
        check_act("rem2b", 4'b0001);
        reset = 1'b1;
        #1;
        check_act("async_rst_act", 4'b0000);
        check("async_rst_moves", 32'(moves), 0);
        check("async_rst_items", 32'(items), 0);
        check("async_rst_full", 32'(full), 0);
        reset = 1'b0;
        tick();
        check_act("rst_to_seek", 4'b1000);

        // moves saturates
        for (int i = 0; i < 259; i++) tick();
        check("moves_sat", 32'(moves), 255);
        check_act("sat_adv", 4'b1000);

        // walls everywhere: watchdog
        do_reset();
        drive(1, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_act("wd_turn", 4'b0100);
            check("wd_not_stuck", 32'(stuck), 0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
`ifdef ROBO_WATCHDOG_EN
            check_act("halt_act", 4'b0000);
            check("halt_stuck", 32'(stuck), 1);
`else
            check_act("no_wd_turn", 4'b0100);
            check("no_wd_stuck", 32'(stuck), 0);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
